// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : wide_add_seq
// Brief   : Multi-precision add/subtract sequencer driving a 16-bit registered
//           adder one slice per pass, LSW first, with carry chaining.
// Revision: 1.0  initial release
// ============================================================================
module wide_add_seq #(
    parameter int WORDS   = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [16*WORDS-1:0] op_a,
    input  logic [16*WORDS-1:0] op_b,
    output logic [15:0]         add_a,
    output logic [15:0]         add_b,
    output logic                add_ci,
    input  logic [15:0]         add_s,
    input  logic                add_co,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] result,
    output logic                cout,
    output logic                ovf
);

    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam int CW = $clog2(ADD_LAT + 1);

    localparam logic [IW-1:0] C_LAST_IDX  = IW'(WORDS - 1);
    localparam logic [CW-1:0] C_LAST_WAIT = CW'(ADD_LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_wait;
    logic [W-17:0] r_a;
    logic [W-17:0] r_b;
    logic [W-17:0] r_acc;
    logic          r_a_msb;
    logic          r_b_msb;

    logic [W-1:0]  w_b_eff;
    logic [W-17:0] w_acc_next;

    // Subtraction is A + ~B + 1, so B is inverted once at acceptance
    assign w_b_eff = sub ? ~op_b : op_b;

    // Lower slices shift in from the top; after WORDS-1 captures they sit in place
    generate
        if (WORDS > 2) begin : g_acc_wide
            assign w_acc_next = {add_s, r_acc[W-17:16]};
        end else begin : g_acc_narrow
            assign w_acc_next = add_s;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_wait  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            add_a   <= '0;
            add_b   <= '0;
            add_ci  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        add_a   <= op_a[15:0];
                        add_b   <= w_b_eff[15:0];
                        add_ci  <= sub ? 1'b1 : cin;
                        r_a     <= op_a[W-1:16];
                        r_b     <= w_b_eff[W-1:16];
                        r_a_msb <= op_a[W-1];
                        r_b_msb <= w_b_eff[W-1];
                        r_idx   <= '0;
                        r_wait  <= '0;
                        busy    <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_wait <= r_wait + 1'b1;
                    if (r_wait == C_LAST_WAIT) begin
                        r_state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    r_wait <= '0;
                    if (r_idx == C_LAST_IDX) begin
                        result  <= {add_s, r_acc};
                        cout    <= add_co;
                        ovf     <= (r_a_msb == r_b_msb) && (add_s[15] != r_a_msb);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc   <= w_acc_next;
                        add_a   <= r_a[15:0];
                        add_b   <= r_b[15:0];
                        add_ci  <= add_co;
                        r_a     <= r_a >> 16;
                        r_b     <= r_b >> 16;
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// Testbench for wide_add_seq with a two-stage registered 16-bit adder model.
module tb_wide_add_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_ci;
    logic [15:0] add_s;
    logic        add_co;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        cout;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wide_add_seq #(.WORDS(4), .ADD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .op_a(op_a), .op_b(op_b), .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_s(add_s), .add_co(add_co), .busy(busy), .done(done),
        .result(result), .cout(cout), .ovf(ovf)
    );

    // Adder: inputs sampled at one edge, sum/co valid after the next
    logic [16:0] p1 = '0;
    logic [16:0] p2 = '0;
    always @(posedge clk) begin
        p1 <= 17'(add_a) + 17'(add_b) + 17'(add_ci);
        p2 <= p1;
    end
    assign add_s  = p2[15:0];
    assign add_co = p2[16];

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic        c;
        logic [63:0] res;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                          input logic c, output logic [63:0] res, output logic co,
                          output logic ov, output int lat, output logic [15:0] ci_bits);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = 64'hDEAD_BEEF_0BAD_F00D; op_b = 64'h0123_4567_89AB_CDEF;
        sub = ~s; cin = ~c;
        check("busy_after_start", 64'(busy), 64'd1);
        lat = 0;
        ci_bits = '0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k < 16) ci_bits[k] = add_ci;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done");
        end
        res = result; co = cout; ov = ovf;
    endtask

    logic [63:0] r_res;
    logic        r_co, r_ov;
    int          r_lat;
    logic [15:0] r_ci;
    int          ndone, done_at;
    logic [63:0] ra, rb, bb;
    logic        rs;
    logic [64:0] gold;

    initial begin
        vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
        vt[1] = '{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vt[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vt[3] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vt[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                  64'h2222_2222_2222_2211, 1'b0, 1'b0};
        vt[5] = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
        vt[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_add_a", 64'(add_a), 64'd0);
        check("rst_add_b", 64'(add_b), 64'd0);
        check("rst_add_ci", 64'(add_ci), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].s, vt[i].c, r_res, r_co, r_ov, r_lat, r_ci);
            check($sformatf("vec%0d_result", i), r_res, vt[i].res);
            check($sformatf("vec%0d_cout", i), 64'(r_co), 64'(vt[i].co));
            check($sformatf("vec%0d_ovf", i), 64'(r_ov), 64'(vt[i].ov));
            check($sformatf("vec%0d_latency", i), 64'(r_lat), 64'd12);
            if (i == 0) begin
                check("ripple_ci_slice1", 64'(r_ci[3]), 64'd1);
                check("ripple_ci_slice2", 64'(r_ci[6]), 64'd1);
                check("ripple_ci_slice3", 64'(r_ci[9]), 64'd1);
            end
        end

        // start while busy and in the done cycle must be ignored
        @(negedge clk);
        op_a = 64'd1; op_b = 64'd2; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; done_at = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 3 || c == 12) begin
                start = 1'b1; op_a = 64'd9; op_b = 64'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                done_at = c;
            end
        end
        start = 1'b0;
        check("busyprot_done_count", 64'(ndone), 64'd1);
        check("busyprot_done_cycle", 64'(done_at), 64'd12);
        check("busyprot_result", result, 64'd3);
        check("busyprot_busy_low", 64'(busy), 64'd0);
        run_op(64'd9, 64'd9, 1'b0, 1'b0, r_res, r_co, r_ov, r_lat, r_ci);
        check("restart_result", r_res, 64'd18);
        check("restart_latency", 64'(r_lat), 64'd12);

        // reset mid-operation aborts with no done
        @(negedge clk);
        op_a = 64'h1111_2222_3333_4444; op_b = 64'h0101_0101_0101_0101;
        sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_result", result, 64'd0);
        check("midrst_add_a", 64'(add_a), 64'd0);
        check("midrst_add_b", 64'(add_b), 64'd0);
        check("midrst_add_ci", 64'(add_ci), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'd0);
        run_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, r_res, r_co, r_ov, r_lat, r_ci);
        check("postrst_result", r_res, 64'h0000_0001_0000_0000);
        check("postrst_latency", 64'(r_lat), 64'd12);

        // back-to-back random operations against a 65-bit model
        for (int t = 0; t < 3; t++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            bb = rs ? ~rb : rb;
            gold = {1'b0, ra} + {1'b0, bb} + 65'(rs);
            run_op(ra, rb, rs, 1'b0, r_res, r_co, r_ov, r_lat, r_ci);
            check($sformatf("b2b%0d_result", t), r_res, gold[63:0]);
            check($sformatf("b2b%0d_cout", t), 64'(r_co), 64'(gold[64]));
            check($sformatf("b2b%0d_ovf", t), 64'(r_ov),
                  64'((ra[63] == bb[63]) && (gold[63] != ra[63])));
            check($sformatf("b2b%0d_latency", t), 64'(r_lat), 64'd12);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
